// File: rtl/md5_round_ctrl.sv
// MD5 round sequencer: LOAD, 64 RUN rounds, FINAL; decodes func/widx/shift.
// Optional stall_i input enabled by defining MD5_ROUND_STALL_EN.
module md5_round_ctrl (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
`ifdef MD5_ROUND_STALL_EN
  input  logic       stall_i,
`endif
  output logic       busy_o,
  output logic       load_o,
  output logic       valid_o,
  output logic [0:5] round_o,
  output logic [0:1] func_o,
  output logic [0:3] widx_o,
  output logic [0:4] shift_o,
  output logic       add_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FINAL
  } state_e;

  state_e     state_q, state_d;
  logic [0:5] cnt_q, cnt_d;
  logic [0:5] round_q;
  logic [0:1] func_q, func_d;
  logic [0:3] widx_q, widx_d;
  logic [0:4] shift_q, shift_d;
  logic [3:0] idx;
  logic       stall;

`ifdef MD5_ROUND_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        if (!stall) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (cnt_q == 6'd63) state_d = FINAL;
          else                cnt_d   = cnt_q + 6'd1;
        end
      end
      FINAL: begin
        if (!stall) state_d = start_i ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode the round that will be presented next cycle.
  always_comb begin
    idx    = cnt_d[2:5];
    func_d = cnt_d[0:1];
    widx_d = idx;
    unique case (func_d)
      2'd0:    widx_d = idx;
      2'd1:    widx_d = idx * 4'd5 + 4'd1;
      2'd2:    widx_d = idx * 4'd3 + 4'd5;
      default: widx_d = idx * 4'd7;
    endcase
    unique case ({func_d, cnt_d[4:5]})
      4'h0:    shift_d = 5'd7;
      4'h1:    shift_d = 5'd12;
      4'h2:    shift_d = 5'd17;
      4'h3:    shift_d = 5'd22;
      4'h4:    shift_d = 5'd5;
      4'h5:    shift_d = 5'd9;
      4'h6:    shift_d = 5'd14;
      4'h7:    shift_d = 5'd20;
      4'h8:    shift_d = 5'd4;
      4'h9:    shift_d = 5'd11;
      4'hA:    shift_d = 5'd16;
      4'hB:    shift_d = 5'd23;
      4'hC:    shift_d = 5'd6;
      4'hD:    shift_d = 5'd10;
      4'hE:    shift_d = 5'd15;
      default: shift_d = 5'd21;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Round outputs only change while in RUN; they hold elsewhere.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      round_q <= '0;
      func_q  <= '0;
      widx_q  <= '0;
      shift_q <= '0;
    end else if (state_d == RUN) begin
      round_q <= cnt_d;
      func_q  <= func_d;
      widx_q  <= widx_d;
      shift_q <= shift_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign load_o  = (state_q == LOAD) && !stall;
  assign valid_o = (state_q == RUN) && !stall;
  assign add_o   = (state_q == FINAL) && !stall;
  assign done_o  = (state_q == FINAL) && !stall;
  assign round_o = round_q;
  assign func_o  = func_q;
  assign widx_o  = widx_q;
  assign shift_o = shift_q;

endmodule
